// File: rtl/player_motion.sv
// player_motion: turns held keycodes into the player box position, jump arc and
// swing strobe, updated once per video frame. Define PLAYER_DOUBLE_JUMP_EN for a mid-air jump.
module player_motion #(
    parameter logic [9:0] X_START      = 10'd100,
    parameter logic [9:0] Y_GROUND     = 10'd360,
    parameter logic [9:0] X_MIN        = 10'd0,
    parameter logic [9:0] X_MAX        = 10'd260,
    parameter logic [9:0] STEP         = 10'd2,
    parameter logic [9:0] JUMP_V       = 10'd12,
    parameter logic [9:0] GRAVITY      = 10'd1,
    parameter logic [3:0] SWING_FRAMES = 4'd8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       airborne,
    output logic       swing
);

    localparam logic [7:0] KEY_A  = 8'h04;
    localparam logic [7:0] KEY_D  = 8'h07;
    localparam logic [7:0] KEY_W  = 8'h1A;
    localparam logic [7:0] KEY_SP = 8'h2C;

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } jump_state_t;

    jump_state_t state, state_next;

    logic        frame_clk_d;
    logic        frame_pulse;
    logic        w_prev, sp_prev;
    logic        key_a, key_d, key_w, key_sp;
    logic        w_edge, sp_edge;
    logic [9:0]  vy, vy_next;
    logic [9:0]  x_next, y_next;
    logic [10:0] x_ext, x_low_limit, x_add, y_sum;
    logic [3:0]  swing_cnt, swing_cnt_next;
    logic        swing_next;
    logic        airborne_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic        dj_used, dj_used_next;
`endif

    assign key_a  = (keycode0 == KEY_A)  || (keycode1 == KEY_A);
    assign key_d  = (keycode0 == KEY_D)  || (keycode1 == KEY_D);
    assign key_w  = (keycode0 == KEY_W)  || (keycode1 == KEY_W);
    assign key_sp = (keycode0 == KEY_SP) || (keycode1 == KEY_SP);

    assign w_edge  = key_w  & ~w_prev;
    assign sp_edge = key_sp & ~sp_prev;

    // frame_clk_d only tracks the input, so releasing Reset never fakes a frame edge
    always_ff @(posedge clk) begin
        frame_clk_d <= frame_clk;
        if (Reset)
            frame_pulse <= 1'b0;
        else
            frame_pulse <= frame_clk & ~frame_clk_d;
    end

    always_ff @(posedge clk) begin
        if (Reset)
            state <= GROUND;
        else if (frame_pulse)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        vy_next    = vy;
        y_next     = player_y;
        y_sum      = '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_used_next = dj_used;
`endif
        case (state)
            GROUND: begin
                if (w_edge) begin
                    vy_next    = JUMP_V;
                    state_next = RISE;
                end
            end
            RISE: begin
                y_next  = (vy > player_y) ? '0 : player_y - vy;
                vy_next = (vy > GRAVITY) ? vy - GRAVITY : '0;
                if (vy_next == '0)
                    state_next = FALL;
            end
            FALL: begin
                vy_next = vy + GRAVITY;
                y_sum   = {1'b0, player_y} + {1'b0, vy_next};
                if (y_sum >= {1'b0, Y_GROUND}) begin
                    y_next     = Y_GROUND;
                    vy_next    = '0;
                    state_next = GROUND;
                end else begin
                    y_next = y_sum[9:0];
                end
            end
            default: begin
                state_next = GROUND;
                vy_next    = '0;
            end
        endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
        // The mid-air jump keeps this frame's y step and only replaces the speed
        if (state != GROUND && w_edge && !dj_used) begin
            vy_next      = JUMP_V;
            state_next   = RISE;
            dj_used_next = 1'b1;
        end else if (state == FALL && state_next == GROUND) begin
            dj_used_next = 1'b0;
        end
`endif
    end

    always_comb begin
        x_ext       = {1'b0, player_x};
        x_low_limit = {1'b0, X_MIN} + {1'b0, STEP};
        x_add       = x_ext + {1'b0, STEP};
        x_next      = player_x;
        if (key_a && !key_d) begin
            if (x_ext < x_low_limit)
                x_next = X_MIN;
            else
                x_next = player_x - STEP;
        end else if (key_d && !key_a) begin
            if (x_add > {1'b0, X_MAX})
                x_next = X_MAX;
            else
                x_next = x_add[9:0];
        end

        swing_cnt_next = swing_cnt;
        swing_next     = swing;
        if (swing_cnt != 4'd0) begin
            swing_cnt_next = swing_cnt - 4'd1;
            if (swing_cnt == 4'd1)
                swing_next = 1'b0;
        end else if (sp_edge) begin
            swing_cnt_next = SWING_FRAMES;
            swing_next     = 1'b1;
        end

        airborne_next = (state_next != GROUND);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            player_x  <= X_START;
            player_y  <= Y_GROUND;
            vy        <= '0;
            airborne  <= 1'b0;
            swing     <= 1'b0;
            swing_cnt <= '0;
            w_prev    <= 1'b0;
            sp_prev   <= 1'b0;
        end else if (frame_pulse) begin
            player_x  <= x_next;
            player_y  <= y_next;
            vy        <= vy_next;
            airborne  <= airborne_next;
            swing     <= swing_next;
            swing_cnt <= swing_cnt_next;
            w_prev    <= key_w;
            sp_prev   <= key_sp;
        end
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    always_ff @(posedge clk) begin
        if (Reset)
            dj_used <= 1'b0;
        else if (frame_pulse)
            dj_used <= dj_used_next;
    end
`endif

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: frame-by-frame directed vectors; expected outputs are queued by the
// stimulus and checked by an independent monitor when the DUT presents new outputs.
`timescale 1ns/1ps
module tb_player_motion;

    localparam logic [7:0] KEY_A  = 8'h04;
    localparam logic [7:0] KEY_D  = 8'h07;
    localparam logic [7:0] KEY_W  = 8'h1A;
    localparam logic [7:0] KEY_SP = 8'h2C;
    localparam logic [7:0] NOKEY  = 8'h00;

    localparam logic [3:0] M_X   = 4'b1000;
    localparam logic [3:0] M_Y   = 4'b0100;
    localparam logic [3:0] M_AIR = 4'b0010;
    localparam logic [3:0] M_SW  = 4'b0001;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic       clk       = 1'b0;
    logic       Reset     = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode0  = 8'h00;
    logic [7:0] keycode1  = 8'h00;
    logic [9:0] player_x, player_y;
    logic       airborne, swing;

    typedef struct packed {
        logic [3:0] mask;
        logic [9:0] x;
        logic [9:0] y;
        logic       air;
        logic       sw;
    } expect_t;

    expect_t expQ[$];
    string   nameQ[$];
    int      checks = 0;
    int      errors = 0;

    // Hand-derived y after each frame of a jump from y=360 (12 rising, 12 falling)
    int jumpY [24] = '{348, 337, 327, 318, 310, 303, 297, 292, 288, 285, 283, 282,
                       283, 285, 288, 292, 297, 303, 310, 318, 327, 337, 348, 360};

    always #5 clk = ~clk;

    player_motion dut (
        .clk       (clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode0  (keycode0),
        .keycode1  (keycode1),
        .player_x  (player_x),
        .player_y  (player_y),
        .airborne  (airborne),
        .swing     (swing)
    );

    task automatic applyStimulus(input logic [7:0] k0, input logic [7:0] k1,
                                 input logic [3:0] mask, input int ex, input int ey,
                                 input logic ea, input logic es, input string name);
        expect_t e;
        @(negedge clk);
        keycode0 = k0;
        keycode1 = k1;
        e.mask = mask;
        e.x    = 10'(ex);
        e.y    = 10'(ey);
        e.air  = ea;
        e.sw   = es;
        expQ.push_back(e);
        nameQ.push_back(name);
        frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyReset(input string name);
        expect_t e;
        @(negedge clk);
        e.mask = M_ALL;
        e.x    = 10'd100;
        e.y    = 10'd360;
        e.air  = 1'b0;
        e.sw   = 1'b0;
        expQ.push_back(e);
        nameQ.push_back(name);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic checkOutput();
        expect_t e;
        string   n;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: output event with no queued expectation");
            return;
        end
        e = expQ.pop_front();
        n = nameQ.pop_front();
        if (e.mask[3]) begin
            checks++;
            if (player_x !== e.x) begin
                errors++;
                $display("[TB] FAIL %s player_x: actual %0d required %0d", n, player_x, e.x);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (player_y !== e.y) begin
                errors++;
                $display("[TB] FAIL %s player_y: actual %0d required %0d", n, player_y, e.y);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (airborne !== e.air) begin
                errors++;
                $display("[TB] FAIL %s airborne: actual %0b required %0b", n, airborne, e.air);
            end
        end
        if (e.mask[0]) begin
            checks++;
            if (swing !== e.sw) begin
                errors++;
                $display("[TB] FAIL %s swing: actual %0b required %0b", n, swing, e.sw);
            end
        end
    endtask

    // Outputs settle one clk after Reset, two clks after a frame_clk rise
    initial begin
        forever begin
            @(posedge frame_clk or posedge Reset);
            if (Reset)
                @(negedge clk);
            else
                repeat (2) @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);

        applyReset("reset_state");
        for (int i = 1; i <= 10; i++)
            applyStimulus(KEY_D, NOKEY, (i == 10) ? M_ALL : M_X, 100 + 2 * i, 360,
                          1'b0, 1'b0, "walk_right");

        applyReset("reset_left");
        for (int i = 1; i <= 60; i++)
            applyStimulus(KEY_A, NOKEY, M_X, (100 - 2 * i < 0) ? 0 : 100 - 2 * i, 360,
                          1'b0, 1'b0, "clamp_left");
        for (int i = 1; i <= 140; i++)
            applyStimulus(NOKEY, KEY_D, M_X, (2 * i > 260) ? 260 : 2 * i, 360,
                          1'b0, 1'b0, "clamp_right");

        applyReset("reset_jump");
        applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, 360, 1'b1, 1'b0, "jump_launch");
        for (int k = 1; k <= 24; k++)
            applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, jumpY[k-1], (k < 24), 1'b0,
                          "jump_arc");
        for (int k = 1; k <= 4; k++)
            applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, 360, 1'b0, 1'b0, "jump_hold");

        applyReset("reset_swing");
        for (int i = 0; i < 20; i++)
            applyStimulus(NOKEY, KEY_SP, M_SW, 100, 360, 1'b0, (i < 8), "swing_hold");
        applyStimulus(NOKEY, NOKEY, M_SW, 100, 360, 1'b0, 1'b0, "swing_release");
        for (int j = 0; j < 12; j++)
            applyStimulus((j == 2) ? NOKEY : KEY_SP, NOKEY, M_SW, 100, 360, 1'b0, (j < 8),
                          "swing_no_retrigger");

        applyReset("reset_combo");
        applyStimulus(KEY_W, KEY_SP, M_ALL, 100, 360, 1'b1, 1'b1, "combo_launch");
        for (int k = 1; k <= 5; k++)
            applyStimulus(KEY_W, KEY_SP, M_ALL, 100, jumpY[k-1], 1'b1, 1'b1, "combo_rise");
        applyReset("reset_midair");
        applyStimulus(KEY_W, KEY_SP, M_ALL, 100, 360, 1'b1, 1'b1, "relaunch_after_reset");

        applyReset("reset_both");
        applyStimulus(KEY_A, KEY_D, M_ALL, 100, 360, 1'b0, 1'b0, "a_and_d");
        applyStimulus(KEY_D, KEY_A, M_X, 100, 360, 1'b0, 1'b0, "d_and_a");
        applyStimulus(KEY_W, KEY_D, M_ALL, 102, 360, 1'b1, 1'b0, "jump_and_right");
        applyStimulus(KEY_W, KEY_D, M_ALL, 104, 348, 1'b1, 1'b0, "rise_and_right");

`ifdef PLAYER_DOUBLE_JUMP_EN
        applyReset("reset_dj");
        applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, 360, 1'b1, 1'b0, "dj_launch");
        for (int k = 1; k <= 10; k++)
            applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, jumpY[k-1], 1'b1, 1'b0, "dj_rise1");
        applyStimulus(NOKEY, NOKEY, M_Y | M_AIR, 100, 283, 1'b1, 1'b0, "dj_release");
        applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, 282, 1'b1, 1'b0, "dj_second");
        for (int k = 1; k <= 12; k++)
            applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, jumpY[k-1] - 78, 1'b1, 1'b0,
                          "dj_rise2");
        applyStimulus(NOKEY, NOKEY, M_Y | M_AIR, 100, 205, 1'b1, 1'b0, "dj_fall");
        applyStimulus(KEY_W, NOKEY, M_Y | M_AIR, 100, 207, 1'b1, 1'b0, "dj_third_ignored");
`endif

        repeat (5) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Per-player motion controller directly upstream of the shuttle block.
- Converts USB keyboard keycodes into the player's box position (`player_x`, `player_y`) plus a swing strobe, once per video frame.
- The shuttle block consumes `player_x`/`player_y` for its hit box; the sprite renderer consumes all outputs.
- Handles horizontal walking with court clamping, a gravity-based jump state machine, and a fixed-length swing window.

Parameters:
- X_START, 10'd100: reset x of the player box's top-left corner.
- Y_GROUND, 10'd360: ground-level y of the box's top-left corner.
- X_MIN, 10'd0: leftmost legal x.
- X_MAX, 10'd260: rightmost legal x (net side minus 40 px box width).
- STEP, 10'd2: horizontal pixels moved per frame.
- JUMP_V, 10'd12: initial upward speed in px/frame.
- GRAVITY, 10'd1: speed change per frame.
- SWING_FRAMES, 4'd8: frames that `swing` stays high.

Ports:
- clk, input, 1: system clock (50 MHz).
- Reset, input, 1: synchronous, active-high reset.
- frame_clk, input, 1: vsync-rate frame clock, asynchronous in phase.
- keycode0, input, 8: first held key (USB HID usage code; 0x00 = none).
- keycode1, input, 8: second held key.
- player_x, output, 10: box top-left x.
- player_y, output, 10: box top-left y.
- airborne, output, 1: high while the state is not GROUND.
- swing, output, 1: high during the swing window.

Behaviour:
- Reset is `Reset`, synchronous, active-high; clock is `clk`. Values on Reset:
  - `player_x` = X_START, `player_y` = Y_GROUND.
  - state = GROUND, vy = 0, `swing` = 0, swing counter = 0, key-history flops = 0.
  - These apply even mid-jump or mid-swing.
- Frame pulse:
  - `frame_clk` is registered; the pulse is the registered form of (frame_clk & ~frame_clk_d).
  - The pulse is one `clk` wide.
  - All state updates happen only on pulse cycles, so outputs change 2 `clk` after the `frame_clk` rising edge.
- Key decode: a key counts as pressed if either keycode equals its code.
  - A = 0x04 (left), D = 0x07 (right), W = 0x1A (jump), Space = 0x2C (swing).
  - `w_edge` / `sp_edge` = pressed now and not pressed on the previous pulse. The history is updated each pulse.
- Horizontal movement (any state):
  - A only: if x < X_MIN+STEP then x = X_MIN, else x -= STEP.
  - D only: if x+STEP > X_MAX then x = X_MAX, else x += STEP.
  - Both or neither: no change.
  - Use 11-bit intermediate sums; no wrap is allowed.
- Jump FSM (vy is an unsigned 10-bit speed magnitude):
  - GROUND: on `w_edge`, vy = JUMP_V and go to RISE. `y` is unchanged this frame.
  - RISE: y = y - vy, saturating at 0; vy = vy - GRAVITY. If the new vy == 0, go to FALL.
  - FALL: vy = vy + GRAVITY; y = y + vy (new vy). If the result is ≥ Y_GROUND, then y = Y_GROUND, vy = 0, and go to GROUND.
  - With defaults: rise 78 px over 12 frames (peak y = 282), then fall 78 px over 12 frames; 24 airborne frames in total.
- `airborne` is registered, high in RISE and FALL.
- Swing:
  - On `sp_edge` with counter == 0: counter = SWING_FRAMES, `swing` = 1.
  - Each later pulse: decrement the counter; `swing` drops on the pulse where the counter reaches 0.
  - `sp_edge` while the counter is non-zero is ignored (no retrigger).
  - Holding Space yields exactly one swing.
  - Swing is independent of the jump state.
- Simultaneous events in one pulse: horizontal move, jump step and swing update are all applied together.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- When defined:
  - One extra jump is allowed while airborne: `w_edge` in RISE or FALL with `dj_used` == 0 sets vy = JUMP_V, state RISE, `dj_used` = 1.
  - `dj_used` clears on landing and on Reset.
  - The y saturation at 0 still applies.
- When undefined: `w_edge` in RISE/FALL is ignored, and no `dj_used` flop exists.

Test Plan:
1. Reset, then keycode0 = 0x07 held for 10 pulses -> `player_x` = 120, `player_y` = 360, `airborne` = 0.
2. Start at x = 100, hold 0x04 for 60 pulses -> x reaches 0 at pulse 50 and stays 0. Separately, hold 0x07 until x = 260 -> x holds at 260.
3. W pressed (held) from GROUND:
   - Pulse 1 -> y = 348, `airborne` = 1.
   - Pulse 12 -> y = 282.
   - Pulse 24 -> y = 360, `airborne` = 0.
   - Continued hold causes no new jump.
4. Space held 20 pulses -> `swing` high for exactly 8 pulses. Release one pulse, press again -> another 8-pulse window. A press during the window is ignored.
5. Reset asserted on the pulse after jump pulse 5 while swinging -> next `clk`: x = 100, y = 360, `airborne` = 0, `swing` = 0.
6. Simultaneous keys:
   - keycode0 = 0x04 and keycode1 = 0x07 -> x unchanged.
   - keycode0 = 0x1A and keycode1 = 0x07 -> pulse 1 gives x += 2 while entering RISE.
   - With PLAYER_DOUBLE_JUMP_EN: re-pressing W at pulse 12 gives peak y = 204; a third press is ignored.
